// File: rtl/fetch_unit_if.sv
// fetch_unit_if -- bus bundle between the fetch unit, code memory and the
// instruction consumer.
//
// Signals:
//   codeAddr   code-memory read address (driven by the fetch unit)
//   codeValue  three consecutive code words starting at codeAddr, word 0 in
//              the low bits (combinational, driven by the memory)
//   cmd/arg0/arg1  held instruction word and its two argument words
//   cmdValid   held instruction is valid (driven by the fetch unit)
//   cmdReady   consumer accepts the held instruction (driven by the consumer)
//
// Modports:
//   master  fetch unit side
//   slave   memory / consumer side
interface fetch_unit_if #(
  parameter int WORD_SIZE_ = 32,
  parameter int ADDR_SIZE_ = 32
);
  logic [ADDR_SIZE_-1:0]   codeAddr;
  logic [3*WORD_SIZE_-1:0] codeValue;
  logic [WORD_SIZE_-1:0]   cmd;
  logic [WORD_SIZE_-1:0]   arg0;
  logic [WORD_SIZE_-1:0]   arg1;
  logic                    cmdValid;
  logic                    cmdReady;

  modport master (
    output codeAddr, cmd, arg0, arg1, cmdValid,
    input  codeValue, cmdReady
  );

  modport slave (
    input  codeAddr, cmd, arg0, arg1, cmdValid,
    output codeValue, cmdReady
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit -- instruction fetch stage with a one-entry output holding
// register, jump redirect and illegal-instruction halt.
//
// Each code word carries its argument count in bits [1:0] (0..2 legal,
// 3 illegal). A capture loads the instruction plus its arguments from the
// three-word code-memory window and advances pc by 1+argc.
//
// Ports:
//   clk        rising-edge clock
//   rstN       asynchronous active-low reset
//   run        fetch enable
//   jumpEn     one-cycle redirect request
//   jumpAddr   redirect target
//   halted     high after an illegal instruction until reset
//   bus        fetch_unit_if.master (code memory + instruction handshake)
//
// Optional feature (macro FETCH_UNIT_PERF_EN):
//   fetchCount  accepted-handshake counter (32-bit, wraps)
//   stallCount  cycles with cmdValid=1 and cmdReady=0 (32-bit, wraps)
module fetch_unit #(
  parameter int                    WORD_SIZE_  = 32,
  parameter int                    ADDR_SIZE_  = 32,
  parameter logic [ADDR_SIZE_-1:0] START_ADDR_ = '0
) (
  input  logic                  clk,
  input  logic                  rstN,
  input  logic                  run,
  input  logic                  jumpEn,
  input  logic [ADDR_SIZE_-1:0] jumpAddr,
  output logic                  halted,
`ifdef FETCH_UNIT_PERF_EN
  output logic [31:0]           fetchCount,
  output logic [31:0]           stallCount,
`endif
  fetch_unit_if.master          bus
);

  localparam logic [0:0] FETCH = 1'b0;
  localparam logic [0:0] HALT  = 1'b1;

  logic [0:0]            state;
  logic [ADDR_SIZE_-1:0] pc;
  logic [WORD_SIZE_-1:0] cmdReg;
  logic [WORD_SIZE_-1:0] arg0Reg;
  logic [WORD_SIZE_-1:0] arg1Reg;
  logic                  validReg;

  logic [WORD_SIZE_-1:0] word0;
  logic [WORD_SIZE_-1:0] word1;
  logic [WORD_SIZE_-1:0] word2;
  logic [1:0]            argc;
  logic                  inFetch;
  logic                  handshake;
  logic                  capture;
  logic                  illegal;

  assign word0 = bus.codeValue[WORD_SIZE_-1:0];
  assign word1 = bus.codeValue[2*WORD_SIZE_-1:WORD_SIZE_];
  assign word2 = bus.codeValue[3*WORD_SIZE_-1:2*WORD_SIZE_];
  assign argc  = word0[1:0];

  assign inFetch   = (state == FETCH);
  assign handshake = validReg && bus.cmdReady;
  // The holding register can take a new instruction when it is empty or
  // is being drained on this same edge; a jump always suppresses capture.
  assign capture   = inFetch && run && !jumpEn && (!validReg || bus.cmdReady);
  assign illegal   = (argc == 2'd3);

  // Main fetch state: pc, holding register and halt state. A jump wins over
  // capture and backpressure; an illegal word halts with pc left pointing
  // at it so the faulting address stays visible on codeAddr.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state    <= FETCH;
      pc       <= START_ADDR_;
      cmdReg   <= '0;
      arg0Reg  <= '0;
      arg1Reg  <= '0;
      validReg <= 1'b0;
    end else if (inFetch) begin
      if (jumpEn) begin
        pc       <= jumpAddr;
        validReg <= 1'b0;
      end else if (capture) begin
        if (illegal) begin
          state    <= HALT;
          validReg <= 1'b0;
        end else begin
          cmdReg   <= word0;
          arg0Reg  <= (argc != 2'd0) ? word1 : '0;
          arg1Reg  <= (argc == 2'd2) ? word2 : '0;
          validReg <= 1'b1;
          pc       <= pc + ADDR_SIZE_'(argc) + ADDR_SIZE_'(1);
        end
      end else if (handshake) begin
        validReg <= 1'b0;
      end
    end
  end

`ifdef FETCH_UNIT_PERF_EN
  // Performance counters; a handshake on a jump edge still counts as a fetch.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      fetchCount <= '0;
      stallCount <= '0;
    end else begin
      if (handshake) begin
        fetchCount <= fetchCount + 32'd1;
      end
      if (validReg && !bus.cmdReady) begin
        stallCount <= stallCount + 32'd1;
      end
    end
  end
`endif

  assign bus.codeAddr = pc;
  assign bus.cmd      = cmdReg;
  assign bus.arg0     = arg0Reg;
  assign bus.arg1     = arg1Reg;
  assign bus.cmdValid = validReg;
  assign halted       = (state == HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit.
// Directed vector table, hand-written async-reset and pc-wrap sequences,
// then randomized stimulus against a transaction-level reference model.
// Perf-counter checks are included when FETCH_UNIT_PERF_EN is defined.
module tb_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstN;
  logic        run;
  logic        jumpEn;
  logic [31:0] jumpAddr;
  logic        halted;
  logic        run2;
  logic        jumpEn2;
  logic [31:0] jumpAddr2;
  logic        halted2;

  fetch_unit_if #(.WORD_SIZE_(32), .ADDR_SIZE_(32)) bus0 ();
  fetch_unit_if #(.WORD_SIZE_(32), .ADDR_SIZE_(32)) bus1 ();

`ifdef FETCH_UNIT_PERF_EN
  logic [31:0] fetchCount;
  logic [31:0] stallCount;
  logic [31:0] fetchCount2;
  logic [31:0] stallCount2;
`endif

  // Code memory: 256 words, addresses alias modulo 256.
  logic [31:0] mem [256];
  logic [7:0]  i0, i0p1, i0p2, i1, i1p1, i1p2;
  assign i0   = bus0.codeAddr[7:0];
  assign i0p1 = i0 + 8'd1;
  assign i0p2 = i0 + 8'd2;
  assign i1   = bus1.codeAddr[7:0];
  assign i1p1 = i1 + 8'd1;
  assign i1p2 = i1 + 8'd2;
  assign bus0.codeValue = {mem[i0p2], mem[i0p1], mem[i0]};
  assign bus1.codeValue = {mem[i1p2], mem[i1p1], mem[i1]};

  fetch_unit #(.WORD_SIZE_(32), .ADDR_SIZE_(32), .START_ADDR_(32'h0)) dut (
    .clk(clk),
    .rstN(rstN),
    .run(run),
    .jumpEn(jumpEn),
    .jumpAddr(jumpAddr),
    .halted(halted),
`ifdef FETCH_UNIT_PERF_EN
    .fetchCount(fetchCount),
    .stallCount(stallCount),
`endif
    .bus(bus0)
  );

  fetch_unit #(.WORD_SIZE_(32), .ADDR_SIZE_(32), .START_ADDR_(32'hFFFF_FFFF)) dutWrap (
    .clk(clk),
    .rstN(rstN),
    .run(run2),
    .jumpEn(jumpEn2),
    .jumpAddr(jumpAddr2),
    .halted(halted2),
`ifdef FETCH_UNIT_PERF_EN
    .fetchCount(fetchCount2),
    .stallCount(stallCount2),
`endif
    .bus(bus1)
  );

  int tests = 0;
  int fails = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit rd, input bit j, input logic [31:0] ja);
    run           = r;
    bus0.cmdReady = rd;
    jumpEn        = j;
    jumpAddr      = ja;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          run;
    bit          ready;
    bit          jump;
    logic [31:0] jumpAddr;
    logic [31:0] expAddr;
    bit          expValid;
    logic [31:0] expCmd;
    logic [31:0] expArg0;
    logic [31:0] expArg1;
    bit          expHalted;
    int          expFetch;
    int          expStall;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(bit r, bit rd, bit j, logic [31:0] ja, logic [31:0] ea, bit ev,
                                 logic [31:0] ec, logic [31:0] e0, logic [31:0] e1, bit eh,
                                 int ef, int es);
    vec_t v;
    v.run = r; v.ready = rd; v.jump = j; v.jumpAddr = ja;
    v.expAddr = ea; v.expValid = ev; v.expCmd = ec; v.expArg0 = e0; v.expArg1 = e1;
    v.expHalted = eh; v.expFetch = ef; v.expStall = es;
    vecs.push_back(v);
  endfunction

  // ---------------- reference model ----------------
  // Instruction-level view: pc, one held instruction slot, halt flag and
  // event counts, advanced one clock edge at a time from the stated rules.
  logic [31:0] mPc;
  bit          mValid;
  logic [31:0] mCmd, mA0, mA1;
  bit          mHalted;
  int          mFetch, mStall;

  function automatic logic [31:0] memWord(logic [31:0] a);
    return mem[a[7:0]];
  endfunction

  function automatic void modelReset();
    mPc = 32'h0; mValid = 0; mCmd = '0; mA0 = '0; mA1 = '0; mHalted = 0;
    mFetch = 0; mStall = 0;
  endfunction

  function automatic void modelStep(bit r, bit rd, bit j, logic [31:0] ja);
    int n;
    logic [31:0] w;
    if (mValid && rd) mFetch++;
    if (mValid && !rd) mStall++;
    if (mHalted) return;
    if (j) begin
      mPc = ja;
      mValid = 0;
    end else if (r && (!mValid || rd)) begin
      w = memWord(mPc);
      n = int'(w % 4);
      if (n == 3) begin
        mHalted = 1;
        mValid = 0;
      end else begin
        mCmd = w;
        mA0 = (n >= 1) ? memWord(mPc + 1) : 32'h0;
        mA1 = (n == 2) ? memWord(mPc + 2) : 32'h0;
        mValid = 1;
        mPc = mPc + 32'(1 + n);
      end
    end else if (mValid && rd) begin
      mValid = 0;
    end
  endfunction

  task automatic compareModel(input string tag);
    checkOutput({tag, "_addr"}, bus0.codeAddr, mPc);
    checkOutput({tag, "_valid"}, 32'(bus0.cmdValid), 32'(mValid));
    checkOutput({tag, "_halted"}, 32'(halted), 32'(mHalted));
    if (mValid) begin
      checkOutput({tag, "_cmd"}, bus0.cmd, mCmd);
      checkOutput({tag, "_arg0"}, bus0.arg0, mA0);
      checkOutput({tag, "_arg1"}, bus0.arg1, mA1);
    end
`ifdef FETCH_UNIT_PERF_EN
    checkOutput({tag, "_fetchCount"}, fetchCount, 32'(mFetch));
    checkOutput({tag, "_stallCount"}, stallCount, 32'(mStall));
`endif
  endtask

  initial begin
    int haltAge;
    rstN = 1'b0;
    applyStimulus(0, 0, 0, 32'h0);
    run2 = 1'b0; jumpEn2 = 1'b0; jumpAddr2 = 32'h0; bus1.cmdReady = 1'b0;

    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0] = 32'h1;  mem[1] = 32'hAA; mem[2] = 32'h2; mem[3] = 32'h11;
    mem[4] = 32'h22; mem[5] = 32'h0;  mem[6] = 32'h4; mem[7] = 32'h3;
    mem[8'h40] = 32'h100;
    mem[255] = 32'h4;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_addr", bus0.codeAddr, 32'h0);
    checkOutput("rst_valid", 32'(bus0.cmdValid), 32'h0);
    checkOutput("rst_cmd", bus0.cmd, 32'h0);
    checkOutput("rst_arg0", bus0.arg0, 32'h0);
    checkOutput("rst_arg1", bus0.arg1, 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);
    rstN = 1'b1;

    //      run   rdy   jmp   jaddr     addr      valid cmd      arg0    arg1    halt  F  S
    addVec(1'b1, 1'b1, 1'b0, 32'h0,  32'h2,  1'b1, 32'h1,   32'hAA, 32'h0,  1'b0, 0, 0);
    addVec(1'b1, 1'b1, 1'b0, 32'h0,  32'h5,  1'b1, 32'h2,   32'h11, 32'h22, 1'b0, 1, 0);
    addVec(1'b1, 1'b0, 1'b0, 32'h0,  32'h5,  1'b1, 32'h2,   32'h11, 32'h22, 1'b0, 1, 1);
    addVec(1'b1, 1'b0, 1'b0, 32'h0,  32'h5,  1'b1, 32'h2,   32'h11, 32'h22, 1'b0, 1, 2);
    addVec(1'b1, 1'b0, 1'b0, 32'h0,  32'h5,  1'b1, 32'h2,   32'h11, 32'h22, 1'b0, 1, 3);
    addVec(1'b1, 1'b0, 1'b0, 32'h0,  32'h5,  1'b1, 32'h2,   32'h11, 32'h22, 1'b0, 1, 4);
    addVec(1'b1, 1'b1, 1'b0, 32'h0,  32'h6,  1'b1, 32'h0,   32'h0,  32'h0,  1'b0, 2, 4);
    addVec(1'b0, 1'b0, 1'b0, 32'h0,  32'h6,  1'b1, 32'h0,   32'h0,  32'h0,  1'b0, 2, 5);
    addVec(1'b0, 1'b1, 1'b0, 32'h0,  32'h6,  1'b0, 32'h0,   32'h0,  32'h0,  1'b0, 3, 5);
    addVec(1'b1, 1'b0, 1'b0, 32'h0,  32'h7,  1'b1, 32'h4,   32'h0,  32'h0,  1'b0, 3, 5);
    addVec(1'b1, 1'b0, 1'b1, 32'h40, 32'h40, 1'b0, 32'h0,   32'h0,  32'h0,  1'b0, 3, 6);
    addVec(1'b1, 1'b0, 1'b0, 32'h0,  32'h41, 1'b1, 32'h100, 32'h0,  32'h0,  1'b0, 3, 6);
    addVec(1'b1, 1'b1, 1'b1, 32'h7,  32'h7,  1'b0, 32'h0,   32'h0,  32'h0,  1'b0, 4, 6);
    addVec(1'b1, 1'b1, 1'b0, 32'h0,  32'h7,  1'b0, 32'h0,   32'h0,  32'h0,  1'b1, 4, 6);
    addVec(1'b1, 1'b1, 1'b1, 32'h0,  32'h7,  1'b0, 32'h0,   32'h0,  32'h0,  1'b1, 4, 6);
    addVec(1'b0, 1'b0, 1'b0, 32'h0,  32'h7,  1'b0, 32'h0,   32'h0,  32'h0,  1'b1, 4, 6);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].run, vecs[i].ready, vecs[i].jump, vecs[i].jumpAddr);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_addr", i), bus0.codeAddr, vecs[i].expAddr);
      checkOutput($sformatf("vec%0d_valid", i), 32'(bus0.cmdValid), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_halted", i), 32'(halted), 32'(vecs[i].expHalted));
      if (vecs[i].expValid) begin
        checkOutput($sformatf("vec%0d_cmd", i), bus0.cmd, vecs[i].expCmd);
        checkOutput($sformatf("vec%0d_arg0", i), bus0.arg0, vecs[i].expArg0);
        checkOutput($sformatf("vec%0d_arg1", i), bus0.arg1, vecs[i].expArg1);
      end
`ifdef FETCH_UNIT_PERF_EN
      checkOutput($sformatf("vec%0d_fetchCount", i), fetchCount, 32'(vecs[i].expFetch));
      checkOutput($sformatf("vec%0d_stallCount", i), stallCount, 32'(vecs[i].expStall));
`endif
    end

    // Reset mid-cycle out of HALT: takes effect without a clock edge.
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("halt_rst_halted", 32'(halted), 32'h0);
    checkOutput("halt_rst_addr", bus0.codeAddr, 32'h0);
    rstN = 1'b1;

    // Capture one instruction, then pull reset mid-cycle while it is held.
    applyStimulus(1, 0, 0, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("async_pre_valid", 32'(bus0.cmdValid), 32'h1);
    checkOutput("async_pre_cmd", bus0.cmd, 32'h1);
    checkOutput("async_pre_addr", bus0.codeAddr, 32'h2);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("async_valid", 32'(bus0.cmdValid), 32'h0);
    checkOutput("async_addr", bus0.codeAddr, 32'h0);
    checkOutput("async_cmd", bus0.cmd, 32'h0);
    applyStimulus(0, 0, 0, 32'h0);
    rstN = 1'b1;

    // pc wrap: start at 0xFFFFFFFF, argc=0 word there -> pc becomes 0.
    checkOutput("wrap_start_addr", bus1.codeAddr, 32'hFFFF_FFFF);
    run2 = 1'b1;
    bus1.cmdReady = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("wrap_addr", bus1.codeAddr, 32'h0);
    checkOutput("wrap_valid", 32'(bus1.cmdValid), 32'h1);
    checkOutput("wrap_cmd", bus1.cmd, 32'h4);
    run2 = 1'b0;

    // Randomized phase against the reference model.
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      w = $urandom;
      if (w[1:0] == 2'd3 && $urandom_range(0, 29) != 0) w[1:0] = 2'($urandom_range(0, 2));
      mem[i] = w;
    end
    rstN = 1'b0;
    #1;
    modelReset();
    compareModel("rand_init");
    rstN = 1'b1;
    haltAge = 0;

    for (int c = 0; c < 600; c++) begin
      bit r, rd, j;
      logic [31:0] ja;
      r  = ($urandom_range(0, 9) != 0);
      rd = ($urandom_range(0, 3) != 0);
      j  = ($urandom_range(0, 14) == 0);
      ja = 32'($urandom_range(0, 255));
      applyStimulus(r, rd, j, ja);
      modelStep(r, rd, j, ja);
      @(posedge clk);
      #1;
      compareModel($sformatf("rand%0d", c));
      if (mHalted) haltAge++;
      else haltAge = 0;
      if (haltAge > 4 || $urandom_range(0, 99) == 0) begin
        rstN = 1'b0;
        #1;
        modelReset();
        compareModel($sformatf("rand%0d_rst", c));
        rstN = 1'b1;
        haltAge = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
